// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        PUSH
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Occupancy needs one more bit than the pointers so that "full" is representable.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as 0 while empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [DATA_W-1:0]              wdata,
    input  logic                           pop,
    output logic [DATA_W-1:0]              rdata,
    output logic                           full,
    output logic                           empty,
    output logic [level_w(FIFO_DEPTH)-1:0] level
);
    localparam int LVL_W = level_w(FIFO_DEPTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              wr_en, rd_en;

    assign full  = (count == LVL_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: synchroniser, frame FSM, sticky error flags, idle timeout and irq, feeding a FWFT FIFO.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 50000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CNT_W-1:0]               clk_div,
    input  logic [1:0]                     cfg_parity,
    input  logic                           cfg_stop2,
    input  logic                           rx,
    input  logic                           rx_pop,
    input  logic                           err_clr,
    output logic [DATA_W-1:0]              rx_data,
    output logic                           rx_valid,
    output logic                           rx_full,
    output logic [level_w(FIFO_DEPTH)-1:0] rx_level,
    output logic                           frame_err,
    output logic                           parity_err,
    output logic                           overrun,
    output logic                           busy,
    output logic                           irq
);
    localparam int LVL_W = level_w(FIFO_DEPTH);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    logic              rx_meta, rx_s;
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  div_q, cnt;
    logic [1:0]        par_q;
    logic              stop2_q, perr;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shreg;
    logic [TO_W-1:0]   idle_cnt;
    logic              fifo_empty, tick, par_en, start_det, pop_eff, idle_inc;
    logic              do_push, set_ferr, set_perr, set_ovr, full_evt, timeout_evt;

    // NOTE: the synchroniser resets to 1 (line idle) so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign par_en      = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign tick        = (state == START) ? (cnt == (div_q >> 1) - CNT_W'(1))
                                          : (cnt == div_q - CNT_W'(1));
    assign start_det   = (state == IDLE) && !rx_s;
    assign rx_valid    = !fifo_empty;
    assign pop_eff     = rx_pop && rx_valid;
    assign busy        = state inside {START, DATA, PARITY, STOP};
    assign idle_inc    = (state == IDLE) && rx_s && rx_valid && (idle_cnt != TO_W'(TIMEOUT));
    assign timeout_evt = idle_inc && !rx_pop && (idle_cnt == TO_W'(TIMEOUT - 1));
    assign full_evt    = do_push && !pop_eff && (rx_level == LVL_W'(FIFO_DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        do_push   = 1'b0;
        set_ferr  = 1'b0;
        set_perr  = 1'b0;
        set_ovr   = 1'b0;
        case (state)
            IDLE:   if (!rx_s) state_nxt = START;
            START:  if (tick) state_nxt = rx_s ? IDLE : DATA;
            DATA:   if (tick && idx == IDX_W'(DATA_W - 1)) state_nxt = par_en ? PARITY : STOP;
            PARITY: if (tick) state_nxt = STOP;
            STOP: begin
                if (tick) begin
                    if (!rx_s) begin
                        set_ferr  = 1'b1;
                        state_nxt = IDLE;
                    end else if (!stop2_q) begin
                        state_nxt = PUSH;
                    end
                end
            end
            PUSH: begin
                state_nxt = IDLE;
                if (perr)                 set_perr = 1'b1;
                else if (rx_full && !rx_pop) set_ovr = 1'b1;
                else                      do_push  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame configuration is captured at start detect, so mid-frame changes wait for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            par_q   <= PAR_NONE;
            stop2_q <= 1'b0;
            perr    <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s) begin
                div_q   <= clk_div;
                par_q   <= cfg_parity;
                stop2_q <= cfg_stop2;
                perr    <= 1'b0;
            end
        end else if (busy) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
                case (state)
                    DATA: begin
                        shreg[idx] <= rx_s;
                        idx        <= idx + IDX_W'(1);
                    end
                    PARITY:  perr    <= (^shreg) ^ rx_s ^ (par_q == PAR_ODD);
                    STOP:    stop2_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // A flag being set in the same cycle as err_clr stays set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            irq        <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            frame_err  <= set_ferr | (frame_err & ~err_clr);
            parity_err <= set_perr | (parity_err & ~err_clr);
            overrun    <= set_ovr | (overrun & ~err_clr);
            irq        <= full_evt | timeout_evt | (set_ferr & ~frame_err)
                        | (set_perr & ~parity_err) | (set_ovr & ~overrun);
            if (start_det || rx_pop) idle_cnt <= '0;
            else if (idle_inc)       idle_cnt <= idle_cnt + TO_W'(1);
        end
    end

    uart_rx_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (do_push),
        .wdata(shreg),
        .pop  (rx_pop),
        .rdata(rx_data),
        .full (rx_full),
        .empty(fifo_empty),
        .level(rx_level)
    );

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed frame table, randomized frames against a frame-level model, corner sequences.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;
    localparam int TIMEOUT    = 100;
    localparam int LVL_W      = level_w(FIFO_DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CNT_W-1:0]  clk_div = 16'd16;
    logic [1:0]        cfg_parity = PAR_NONE;
    logic              cfg_stop2 = 1'b0;
    logic              rx = 1'b1;
    logic              rx_pop = 1'b0;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid, rx_full, frame_err, parity_err, overrun, busy, irq;
    logic [LVL_W-1:0]  rx_level;

    int n_vec = 0;
    int n_err = 0;
    int irq_cnt = 0;
    int busy_cnt = 0;

    uart_rx_param #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .clk_div(clk_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .rx(rx), .rx_pop(rx_pop), .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_full(rx_full), .rx_level(rx_level), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (irq)  irq_cnt++;
        if (busy) busy_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] d;
        logic [1:0] par;
        logic       s2;
        logic       bad_par;
        logic       bad_stop;
        int         div;
        bit         scr;
        logic       ev;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, " rx_valid"}, rx_valid, 0);
        check({nm, " rx_level"}, rx_level, 0);
        check({nm, " rx_data"}, rx_data, 0);
        check({nm, " rx_full"}, rx_full, 0);
        check({nm, " flags"}, {frame_err, parity_err, overrun}, 0);
        check({nm, " busy_irq"}, {busy, irq}, 0);
    endtask

    // Line bits in transmit order: start, data LSB first, optional parity, one or two stop bits.
    task automatic build_frame(input logic [7:0] d, input logic [1:0] par, input logic s2,
                               input logic bad_par, input logic bad_stop,
                               output logic [15:0] b, output int n);
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) b[1+i] = d[i];
        n = 1 + DATA_W;
        if (par == PAR_EVEN || par == PAR_ODD) begin
            b[n] = (^d) ^ (par == PAR_ODD) ^ bad_par;
            n++;
        end
        b[n] = 1'b1;
        n++;
        if (s2) begin
            b[n] = ~bad_stop;
            n++;
        end
    endtask

    // Frame-level reference: any low stop bit is a frame error, else a parity mismatch, else delivered data.
    task automatic judge(input logic [15:0] b, input int n, input logic [1:0] par,
                         output logic ev, output logic [7:0] ed, output logic ep, output logic ef);
        int first_stop;
        logic par_en;
        par_en = (par == PAR_EVEN || par == PAR_ODD);
        ed = b[8:1];
        first_stop = par_en ? 10 : 9;
        ef = 1'b0;
        for (int i = first_stop; i < n; i++) if (!b[i]) ef = 1'b1;
        ep = !ef && par_en && (((^ed) ^ b[9]) != (par == PAR_ODD));
        ev = !ef && !ep;
    endtask

    task automatic drive_bits(input logic [15:0] b, input int n, input int div);
        for (int i = 0; i < n; i++) begin
            rx = b[i];
            repeat (div) @(negedge clk);
        end
        rx = 1'b1;
        repeat (2 * div) @(negedge clk);
    endtask

    task automatic send_only(input logic [7:0] d, input logic [1:0] par, input logic s2,
                             input logic bad_par, input logic bad_stop, input int div);
        logic [15:0] b;
        int n;
        build_frame(d, par, s2, bad_par, bad_stop, b, n);
        clk_div = CNT_W'(div);
        cfg_parity = par;
        cfg_stop2 = s2;
        drive_bits(b, n, div);
    endtask

    task automatic run_frame(input string nm, input vec_t v);
        logic [15:0] b;
        int n, lat, irq0;
        build_frame(v.d, v.par, v.s2, v.bad_par, v.bad_stop, b, n);
        clk_div = CNT_W'(v.div);
        cfg_parity = v.par;
        cfg_stop2 = v.s2;
        irq0 = irq_cnt;
        lat = -1;
        fork
            drive_bits(b, n, v.div);
            for (int k = 1; k <= (n + 2) * v.div; k++) begin
                @(negedge clk);
                if (rx_valid && lat < 0) lat = k;
            end
            if (v.scr) begin
                repeat (3 * v.div) @(negedge clk);
                clk_div = CNT_W'(v.div + 5);
                cfg_parity = PAR_EVEN;
                cfg_stop2 = 1'b1;
            end
        join
        check({nm, " rx_valid"}, rx_valid, v.ev);
        if (v.ev) begin
            check({nm, " rx_data"}, rx_data, v.ed);
            check({nm, " rx_level"}, rx_level, 1);
            check({nm, " latency_in_window"}, (lat >= v.div * (n - 1)) && (lat <= v.div * n + 4), 1);
        end
        check({nm, " parity_err"}, parity_err, v.ep);
        check({nm, " frame_err"}, frame_err, v.ef);
        check({nm, " overrun"}, overrun, 0);
        check({nm, " irq_pulses"}, irq_cnt - irq0, (v.ep || v.ef) ? 1 : 0);
        if (v.ev) begin
            rx_pop = 1'b1;
            @(negedge clk);
            rx_pop = 1'b0;
            check({nm, " popped_empty"}, {rx_valid, rx_level, rx_data}, 0);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check({nm, " flags_cleared"}, {frame_err, parity_err, overrun}, 0);
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        int first, pulses, b0, i0;
        logic [15:0] b;
        int n;

        tbl[0] = '{8'hA5, PAR_NONE, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h03, PAR_EVEN, 1'b0, 1'b1, 1'b0, 16, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h3C, PAR_NONE, 1'b1, 1'b0, 1'b1, 16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{8'h11, PAR_NONE, 1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[4] = '{8'h80, PAR_ODD,  1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, PAR_EVEN, 1'b0, 1'b0, 1'b0, 8,  1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 2'b11,    1'b0, 1'b0, 1'b0, 5,  1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[7] = '{8'h7E, PAR_ODD,  1'b0, 1'b1, 1'b0, 12, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[8] = '{8'h5C, PAR_NONE, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b1, 8'h5C, 1'b0, 1'b0};
        tbl[9] = '{8'hC3, PAR_EVEN, 1'b1, 1'b0, 1'b0, 4,  1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_zero("post_reset");

        for (int i = 0; i < 10; i++) run_frame($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 24; i++) begin
            rv.d = 8'($urandom);
            rv.par = 2'($urandom_range(0, 3));
            rv.s2 = 1'($urandom_range(0, 1));
            rv.div = $urandom_range(4, 24);
            rv.bad_par = (rv.par == PAR_EVEN || rv.par == PAR_ODD) && ($urandom_range(0, 3) == 0);
            rv.bad_stop = rv.s2 && ($urandom_range(0, 3) == 0);
            rv.scr = 1'b0;
            build_frame(rv.d, rv.par, rv.s2, rv.bad_par, rv.bad_stop, b, n);
            judge(b, n, rv.par, rv.ev, rv.ed, rv.ep, rv.ef);
            run_frame($sformatf("rand%0d", i), rv);
        end

        // FIFO fill to full, then one more frame overruns.
        i0 = irq_cnt;
        for (int i = 1; i <= 4; i++) send_only(8'(i), PAR_NONE, 1'b0, 1'b0, 1'b0, 16);
        check("fill level", rx_level, 4);
        check("fill full", rx_full, 1);
        check("fill irq", irq_cnt - i0, 1);
        check("fill no_overrun", overrun, 0);
        send_only(8'h05, PAR_NONE, 1'b0, 1'b0, 1'b0, 16);
        check("ovr flag", overrun, 1);
        check("ovr irq", irq_cnt - i0, 2);
        check("ovr level", rx_level, 4);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain%0d data", i), rx_data, i);
            rx_pop = 1'b1;
            @(negedge clk);
            rx_pop = 1'b0;
        end
        check("drain empty", {rx_valid, rx_level}, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Idle timeout fires once, TIMEOUT cycles after rx_valid rises.
        first = -1;
        pulses = 0;
        fork
            send_only(8'h42, PAR_NONE, 1'b0, 1'b0, 1'b0, 16);
            begin
                for (int k = 0; k < 400 && !rx_valid; k++) @(negedge clk);
                if (rx_valid) begin
                    for (int k = 1; k <= 150; k++) begin
                        @(negedge clk);
                        if (irq) begin
                            pulses++;
                            if (first < 0) first = k;
                        end
                    end
                end
            end
        join
        check("timeout valid", rx_valid, 1);
        check("timeout first_irq", first, TIMEOUT);
        check("timeout pulses", pulses, 1);
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;

        pulses = 0;
        fork
            send_only(8'h43, PAR_NONE, 1'b0, 1'b0, 1'b0, 16);
            begin
                for (int k = 0; k < 400 && !rx_valid; k++) @(negedge clk);
                check("early_pop valid", rx_valid, 1);
                for (int k = 0; k < 200; k++) begin
                    rx_pop = (k == 50);
                    @(negedge clk);
                    if (irq) pulses++;
                end
                rx_pop = 1'b0;
            end
        join
        check("early_pop no_irq", pulses, 0);
        check("early_pop empty", rx_valid, 0);

        // Short low pulse: start bit rejected at half-bit check.
        clk_div = 16'd16;
        cfg_parity = PAR_NONE;
        cfg_stop2 = 1'b0;
        b0 = busy_cnt;
        i0 = irq_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch busy_cycles", busy_cnt - b0, 8);
        check("glitch idle", {busy, rx_valid, frame_err, parity_err, overrun}, 0);
        check("glitch no_irq", irq_cnt - i0, 0);

        // Reset in the middle of a frame with data queued and a flag set.
        send_only(8'h5A, PAR_NONE, 1'b0, 1'b0, 1'b0, 16);
        check("rst_pre valid", rx_valid, 1);
        send_only(8'h01, PAR_EVEN, 1'b0, 1'b1, 1'b0, 16);
        check("rst_pre perr", parity_err, 1);
        fork
            send_only(8'hFF, PAR_NONE, 1'b0, 1'b0, 1'b0, 16);
            begin
                repeat (60) @(negedge clk);
                check("rst_mid busy", busy, 1);
                rst = 1'b1;
                @(negedge clk);
                check_zero("rst_mid");
                rst = 1'b0;
            end
        join
        check_zero("rst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
